// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS execute-stage ALU: control-unit ALUOp classes,
// R-type funct codes and the internal ALU operation codes.
package mips_alu_pkg;

  localparam logic [3:0] ALUOP_ADD  = 4'b0000;
  localparam logic [3:0] ALUOP_SUB  = 4'b0001;
  localparam logic [3:0] ALUOP_RTYP = 4'b0010;
  localparam logic [3:0] ALUOP_AND  = 4'b0011;
  localparam logic [3:0] ALUOP_OR   = 4'b0100;
  localparam logic [3:0] ALUOP_XOR  = 4'b0101;
  localparam logic [3:0] ALUOP_SLT  = 4'b0110;
  localparam logic [3:0] ALUOP_LUI  = 4'b0111;
  localparam logic [3:0] ALUOP_ADDU = 4'b1000;
  localparam logic [3:0] ALUOP_SLTU = 4'b1001;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13,
    ALU_ZERO = 4'd14
  } alu_ctrl_e;

endpackage

// File: rtl/mips_ex_alu_adder32.sv
// Combinational 32-bit modulo adder; carry out is intentionally discarded.
module adder32 (
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] sum
);

  assign sum = x + y;

endmodule

// File: rtl/mips_ex_alu.sv
// MIPS execute-stage ALU: ALUOp/funct decode, 32-bit ALU with signed overflow,
// standalone PC/branch adder and a sticky overflow status bit.
module mips_ex_alu
  import mips_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic        ovf_sticky,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  output logic [31:0] add_sum
);

  alu_ctrl_e   ctrl;
  logic        var_shift;
  logic [4:0]  sh;
  logic [31:0] sum_ab;
  logic [31:0] diff_ab;

  adder32 u_pc_adder (
    .x   (add_a),
    .y   (add_b),
    .sum (add_sum)
  );

  adder32 u_alu_adder (
    .x   (a),
    .y   (b),
    .sum (sum_ab)
  );

  assign diff_ab = a - b;

  always_comb begin
    ctrl      = ALU_ADD;
    var_shift = 1'b0;
    case (alu_op)
      ALUOP_ADD:  ctrl = ALU_ADD;
      ALUOP_SUB:  ctrl = ALU_SUB;
      ALUOP_AND:  ctrl = ALU_AND;
      ALUOP_OR:   ctrl = ALU_OR;
      ALUOP_XOR:  ctrl = ALU_XOR;
      ALUOP_SLT:  ctrl = ALU_SLT;
      ALUOP_LUI:  ctrl = ALU_LUI;
      ALUOP_ADDU: ctrl = ALU_ADDU;
      ALUOP_SLTU: ctrl = ALU_SLTU;
      ALUOP_RTYP: begin
        case (funct)
          FUNCT_ADD:  ctrl = ALU_ADD;
          FUNCT_ADDU: ctrl = ALU_ADDU;
          FUNCT_SUB:  ctrl = ALU_SUB;
          FUNCT_SUBU: ctrl = ALU_SUBU;
          FUNCT_AND:  ctrl = ALU_AND;
          FUNCT_OR:   ctrl = ALU_OR;
          FUNCT_XOR:  ctrl = ALU_XOR;
          FUNCT_NOR:  ctrl = ALU_NOR;
          FUNCT_SLT:  ctrl = ALU_SLT;
          FUNCT_SLTU: ctrl = ALU_SLTU;
          FUNCT_SLL:  ctrl = ALU_SLL;
          FUNCT_SRL:  ctrl = ALU_SRL;
          FUNCT_SRA:  ctrl = ALU_SRA;
          FUNCT_SLLV: begin ctrl = ALU_SLL; var_shift = 1'b1; end
          FUNCT_SRLV: begin ctrl = ALU_SRL; var_shift = 1'b1; end
          FUNCT_SRAV: begin ctrl = ALU_SRA; var_shift = 1'b1; end
          default:    ctrl = ALU_ZERO;
        endcase
      end
      default:    ctrl = ALU_ADD;
    endcase
  end

  // Variable shifts take their amount from rs[4:0] instead of the shamt field.
  assign sh = var_shift ? a[4:0] : shamt;

  always_comb begin
    result   = 32'h0;
    overflow = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        result   = sum_ab;
        overflow = (a[31] == b[31]) && (sum_ab[31] != a[31]);
      end
      ALU_ADDU: result = sum_ab;
      ALU_SUB: begin
        result   = diff_ab;
        overflow = (a[31] != b[31]) && (diff_ab[31] != a[31]);
      end
      ALU_SUBU: result = diff_ab;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'h0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'h0, (a < b)};
      ALU_SLL:  result = b << sh;
      ALU_SRL:  result = b >> sh;
      ALU_SRA:  result = $unsigned($signed(b) >>> sh);
      ALU_LUI:  result = {b[15:0], 16'h0};
      default:  result = 32'h0;
    endcase
  end

  assign zero     = (result == 32'h0);
  assign alu_ctrl = ctrl;

  always_ff @(posedge clk) begin
    if (reset) ovf_sticky <= 1'b0;
    else       ovf_sticky <= ovf_sticky | overflow;
  end

endmodule

// File: tb/tb_mips_ex_alu.sv
// Directed testbench for mips_ex_alu: hand-computed vectors checked with
// immediate assertions, plus sticky-overflow and adder checks.
module tb_mips_ex_alu;

  logic        clk;
  logic        reset;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        ovf_sticky;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;

  int checks = 0;
  int errors = 0;

  mips_ex_alu dut (
    .clk        (clk),
    .reset      (reset),
    .alu_op     (alu_op),
    .funct      (funct),
    .shamt      (shamt),
    .a          (a),
    .b          (b),
    .alu_ctrl   (alu_ctrl),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .ovf_sticky (ovf_sticky),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] fn, input logic [4:0] sa,
                       input logic [31:0] va, input logic [31:0] vb);
    alu_op = op; funct = fn; shamt = sa; a = va; b = vb;
    #1;
  endtask

  task automatic alu_chk(input string tag, input logic [31:0] exp_res, input logic exp_ovf,
                         input logic [3:0] exp_ctrl);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_overflow"}, {31'h0, overflow}, {31'h0, exp_ovf});
    chk({tag, "_zero"}, {31'h0, zero}, {31'h0, (exp_res == 32'h0)});
    chk({tag, "_ctrl"}, {28'h0, alu_ctrl}, {28'h0, exp_ctrl});
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    add_a = 32'h0;
    add_b = 32'h0;
    drive(4'b0000, 6'h00, 5'd0, 32'h0, 32'h0);
    edge_wait();
    chk("reset_sticky", {31'h0, ovf_sticky}, 32'h0);
    reset = 1'b0;

    // Signed ADD overflow and sticky capture
    drive(4'b0010, 6'h20, 5'd0, 32'h7FFFFFFF, 32'h1);
    alu_chk("add_ovf", 32'h80000000, 1'b1, 4'd0);
    chk("sticky_pre_edge", {31'h0, ovf_sticky}, 32'h0);
    edge_wait();
    chk("sticky_set", {31'h0, ovf_sticky}, 32'h1);

    drive(4'b0001, 6'h00, 5'd0, 32'h1234, 32'h1234);
    alu_chk("beq_equal", 32'h0, 1'b0, 4'd2);
    edge_wait();
    chk("sticky_hold", {31'h0, ovf_sticky}, 32'h1);

    // Reset wins over an overflow in the same cycle
    drive(4'b0001, 6'h00, 5'd0, 32'h80000000, 32'h1);
    alu_chk("sub_ovf", 32'h7FFFFFFF, 1'b1, 4'd2);
    reset = 1'b1;
    edge_wait();
    chk("sticky_reset_wins", {31'h0, ovf_sticky}, 32'h0);
    alu_chk("sub_ovf_in_reset", 32'h7FFFFFFF, 1'b1, 4'd2);
    reset = 1'b0;
    edge_wait();
    chk("sticky_reset_release", {31'h0, ovf_sticky}, 32'h1);
    drive(4'b0000, 6'h00, 5'd0, 32'h1, 32'h2);
    alu_chk("add_plain", 32'h3, 1'b0, 4'd0);
    reset = 1'b1;
    edge_wait();
    chk("sticky_reset_again", {31'h0, ovf_sticky}, 32'h0);
    reset = 1'b0;
    edge_wait();
    chk("sticky_stays_clear", {31'h0, ovf_sticky}, 32'h0);

    // Unsigned forms never flag overflow
    drive(4'b0010, 6'h21, 5'd0, 32'h7FFFFFFF, 32'h1);
    alu_chk("addu", 32'h80000000, 1'b0, 4'd1);
    drive(4'b1000, 6'h00, 5'd0, 32'h7FFFFFFF, 32'h1);
    alu_chk("addiu", 32'h80000000, 1'b0, 4'd1);
    drive(4'b0010, 6'h23, 5'd0, 32'h80000000, 32'h1);
    alu_chk("subu", 32'h7FFFFFFF, 1'b0, 4'd3);
    drive(4'b0010, 6'h22, 5'd0, 32'h10, 32'h3);
    alu_chk("sub_rtype", 32'h0000000D, 1'b0, 4'd2);

    // Compares
    drive(4'b0010, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1);
    alu_chk("slt_neg", 32'h1, 1'b0, 4'd8);
    drive(4'b0010, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1);
    alu_chk("sltu_big", 32'h0, 1'b0, 4'd9);
    drive(4'b0110, 6'h00, 5'd0, 32'h5, 32'hFFFFFFFD);
    alu_chk("slti", 32'h0, 1'b0, 4'd8);
    drive(4'b1001, 6'h00, 5'd0, 32'h5, 32'hFFFFFFFD);
    alu_chk("sltiu", 32'h1, 1'b0, 4'd9);

    // Shifts
    drive(4'b0010, 6'h03, 5'd4, 32'h0, 32'h80000000);
    alu_chk("sra", 32'hF8000000, 1'b0, 4'd12);
    drive(4'b0010, 6'h02, 5'd4, 32'h0, 32'h80000000);
    alu_chk("srl", 32'h08000000, 1'b0, 4'd11);
    drive(4'b0010, 6'h00, 5'd4, 32'h0, 32'h1);
    alu_chk("sll", 32'h00000010, 1'b0, 4'd10);
    drive(4'b0010, 6'h04, 5'd0, 32'd31, 32'h1);
    alu_chk("sllv", 32'h80000000, 1'b0, 4'd10);
    drive(4'b0010, 6'h07, 5'd0, 32'd36, 32'h80000000);
    alu_chk("srav_masked", 32'hF8000000, 1'b0, 4'd12);
    drive(4'b0010, 6'h06, 5'd1, 32'd4, 32'h80000000);
    alu_chk("srlv", 32'h08000000, 1'b0, 4'd11);

    // Logic ops
    drive(4'b0010, 6'h27, 5'd0, 32'h0F0F0F0F, 32'h00FF00FF);
    alu_chk("nor", 32'hF000F000, 1'b0, 4'd7);
    drive(4'b0011, 6'h00, 5'd0, 32'h0F0F0F0F, 32'h00FF00FF);
    alu_chk("andi", 32'h000F000F, 1'b0, 4'd4);
    drive(4'b0100, 6'h00, 5'd0, 32'h0F0F0F0F, 32'h00FF00FF);
    alu_chk("ori", 32'h0FFF0FFF, 1'b0, 4'd5);
    drive(4'b0101, 6'h00, 5'd0, 32'h0F0F0F0F, 32'h00FF00FF);
    alu_chk("xori", 32'h0FF00FF0, 1'b0, 4'd6);
    drive(4'b0010, 6'h24, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    alu_chk("and_rtype", 32'hF000F000, 1'b0, 4'd4);

    // LUI, unknown funct, reserved ALUOp
    drive(4'b0111, 6'h00, 5'd0, 32'h0, 32'hFFFF1234);
    alu_chk("lui", 32'h12340000, 1'b0, 4'd13);
    drive(4'b0010, 6'h3F, 5'd0, 32'h7FFFFFFF, 32'h1);
    alu_chk("funct_unknown", 32'h0, 1'b0, 4'd14);
    drive(4'b1011, 6'h00, 5'd0, 32'h7FFFFFFF, 32'h1);
    alu_chk("aluop_reserved", 32'h80000000, 1'b1, 4'd0);

    // Standalone adder
    add_a = 32'h00400000; add_b = 32'h4;
    #1;
    chk("pc_plus4", add_sum, 32'h00400004);
    add_a = 32'hFFFFFFFC; add_b = 32'h8;
    #1;
    chk("adder_wrap", add_sum, 32'h00000004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
